// File: rtl/gpio_in_debounce_pkg.sv
// Shared constants and helpers for the GPIO input conditioning stage.
package gpio_in_debounce_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int IO_NUM_DEF      = 8;
    localparam int PRESC_W_DEF     = 16;
    localparam int CNT_W_DEF       = 8;

    function automatic logic [31:0] max1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/gpio_db_bit.sv
// One conditioned input bit: synchroniser, stability counter, edge pulses.
module gpio_db_bit
    import gpio_in_debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             pad,
    input  logic             db_en,
    input  logic             tick,
    input  logic [CNT_W-1:0] db_limit,
    output logic             gpio_in,
    output logic             rise,
    output logic             fall
);

    typedef logic [CNT_W:0] cntx_t;

    logic [SYNC_STAGES-1:0] sr;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       nxt_cnt;
    logic                   nxt_val;
    cntx_t                  cnt_x;
    cntx_t                  lim;

    assign sync  = sr[SYNC_STAGES-1];
    assign cnt_x = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign lim   = cntx_t'(max1(32'(db_limit)));

    always_comb begin
        nxt_val = gpio_in;
        nxt_cnt = cnt;
        if (!db_en) begin
            nxt_val = sync;
            nxt_cnt = '0;
        end else if (sync == gpio_in) begin
            nxt_cnt = '0;
        end else if (tick) begin
            if (cnt_x >= lim) begin
                nxt_val = sync;
                nxt_cnt = '0;
            end else begin
                nxt_cnt = cnt_x[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sr      <= '0;
            cnt     <= '0;
            gpio_in <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sr      <= {sr[SYNC_STAGES-2:0], pad};
            cnt     <= nxt_cnt;
            gpio_in <= nxt_val;
            rise    <= ~gpio_in & nxt_val;
            fall    <= gpio_in & ~nxt_val;
        end
    end

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning: shared sample-tick prescaler plus per-bit
// synchronise/debounce/edge-detect slices feeding GPIO_IN.
module gpio_in_debounce
    import gpio_in_debounce_pkg::*;
#(
    parameter int IO_NUM      = IO_NUM_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int PRESC_W     = PRESC_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [IO_NUM-1:0]  pad_in,
    input  logic [IO_NUM-1:0]  db_en,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic [CNT_W-1:0]   db_limit,
    output logic [IO_NUM-1:0]  GPIO_IN,
    output logic [IO_NUM-1:0]  rise_pulse,
    output logic [IO_NUM-1:0]  fall_pulse,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    // >= rather than == so lowering presc_div below pcnt wraps at once.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else if (pcnt >= presc_div) begin
            pcnt <= '0;
            tick <= 1'b1;
        end else begin
            pcnt <= pcnt + {{(PRESC_W-1){1'b0}}, 1'b1};
            tick <= 1'b0;
        end
    end

    for (genvar i = 0; i < IO_NUM; i++) begin : g_bit
        gpio_db_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_bit (
            .PCLK     (PCLK),
            .PRESET   (PRESET),
            .pad      (pad_in[i]),
            .db_en    (db_en[i]),
            .tick     (tick),
            .db_limit (db_limit),
            .gpio_in  (GPIO_IN[i]),
            .rise     (rise_pulse[i]),
            .fall     (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Self-checking bench for gpio_in_debounce: vector table, corner
// sequences and randomized traffic against a reference model.
module tb_gpio_in_debounce;

    localparam int SYNC = 2;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [7:0]  pad_in = '0;
    logic [7:0]  db_en = '0;
    logic [15:0] presc_div = '0;
    logic [7:0]  db_limit = 8'd4;
    logic [7:0]  GPIO_IN;
    logic [7:0]  rise_pulse;
    logic [7:0]  fall_pulse;
    logic        tick;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_in_debounce #(
        .IO_NUM      (8),
        .SYNC_STAGES (SYNC),
        .PRESC_W     (16),
        .CNT_W       (8)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .pad_in     (pad_in),
        .db_en      (db_en),
        .presc_div  (presc_div),
        .db_limit   (db_limit),
        .GPIO_IN    (GPIO_IN),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .tick       (tick)
    );

    always #5 PCLK = ~PCLK;

    // Reference model: pad history queue plus run-length of mismatching ticks.
    logic [7:0] padq[$];
    logic [7:0] m_gpio = '0, m_rise = '0, m_fall = '0;
    bit         m_tick = 0;
    int         m_pcnt = 0;
    int         m_run[8];

    task automatic model_edge();
        logic [7:0] s, ng;
        int lim;
        if (PRESET) begin
            padq.delete();
            for (int k = 0; k < SYNC; k++) padq.push_back(8'h00);
            m_gpio = '0; m_rise = '0; m_fall = '0;
            m_tick = 0; m_pcnt = 0;
            for (int b = 0; b < 8; b++) m_run[b] = 0;
        end else begin
            s   = padq[SYNC-1];
            lim = (db_limit == 8'd0) ? 1 : int'(db_limit);
            ng  = m_gpio;
            for (int b = 0; b < 8; b++) begin
                if (!db_en[b] || s[b] == m_gpio[b]) begin
                    if (!db_en[b]) ng[b] = s[b];
                    m_run[b] = 0;
                end else if (m_tick) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] >= lim) begin
                        ng[b] = s[b];
                        m_run[b] = 0;
                    end
                end
            end
            m_rise = ~m_gpio & ng;
            m_fall = m_gpio & ~ng;
            m_gpio = ng;
            if (m_pcnt >= int'(presc_div)) begin
                m_pcnt = 0; m_tick = 1;
            end else begin
                m_pcnt = m_pcnt + 1; m_tick = 0;
            end
            padq.push_front(pad_in);
            void'(padq.pop_back());
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
    endtask

    task automatic mixed_run();
        logic [7:0] eg, er;
        for (int k = 1; k <= 8; k++) begin
            step();
            eg = (k >= 7) ? 8'hFF : (k >= 3) ? 8'h0F : 8'h00;
            er = (k == 3) ? 8'h0F : (k == 7) ? 8'hF0 : 8'h00;
            chk("mixed_gpio", GPIO_IN, eg);
            chk("mixed_rise", rise_pulse, er);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] pad;
        logic [7:0] en;
        logic [7:0] eg;
        logic [7:0] er;
        logic [7:0] ef;
    } vec_t;

    vec_t tbl[$];

    initial begin
        for (int b = 0; b < 8; b++) m_run[b] = 0;
        // reset then bypass rise and fall; presc_div=0, db_limit=4
        for (int k = 0; k < 3; k++) tbl.push_back('{1, 8'hFF, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00});
        tbl.push_back('{0, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00});
        tbl.push_back('{0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF});
        tbl.push_back('{0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        // debounced bit 0 rise, accepted on edge 6
        tbl.push_back('{1, 8'h00, 8'h01, 0, 0, 0});
        for (int k = 1; k <= 5; k++) tbl.push_back('{0, 8'h01, 8'h01, 0, 0, 0});
        tbl.push_back('{0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00});
        // glitch on edge 4 restarts the count; accepted on edge 10
        tbl.push_back('{1, 8'h00, 8'h01, 0, 0, 0});
        for (int k = 1; k <= 3; k++) tbl.push_back('{0, 8'h01, 8'h01, 0, 0, 0});
        tbl.push_back('{0, 8'h00, 8'h01, 0, 0, 0});
        for (int k = 5; k <= 9; k++) tbl.push_back('{0, 8'h01, 8'h01, 0, 0, 0});
        tbl.push_back('{0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{0, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00});

        presc_div = 16'd0;
        db_limit  = 8'd4;
        foreach (tbl[i]) begin
            PRESET = tbl[i].rst;
            pad_in = tbl[i].pad;
            db_en  = tbl[i].en;
            step();
            chk($sformatf("tbl%0d_gpio", i), GPIO_IN, tbl[i].eg);
            chk($sformatf("tbl%0d_rise", i), rise_pulse, tbl[i].er);
            chk($sformatf("tbl%0d_fall", i), fall_pulse, tbl[i].ef);
        end
        chk("reset_tick", 32'(tick), 32'(1));

        // prescaler period 10, then lowered to 3 while pcnt=7
        do_reset();
        chk("rst_tick", 32'(tick), 32'(0));
        pad_in = 8'h01; db_en = 8'h01; presc_div = 16'd9; db_limit = 8'd2;
        for (int k = 1; k <= 27; k++) begin
            step();
            chk($sformatf("p9_tick%0d", k), 32'(tick), 32'(k == 10 || k == 20));
            chk($sformatf("p9_gpio%0d", k), 32'(GPIO_IN[0]), 32'(k >= 21));
        end
        presc_div = 16'd2;
        for (int k = 28; k <= 37; k++) begin
            step();
            chk($sformatf("p2_tick%0d", k), 32'(tick),
                32'(k == 28 || k == 31 || k == 34 || k == 37));
        end

        // db_limit 0 and 1 behave as bypass timing
        for (int l = 0; l <= 1; l++) begin
            presc_div = 16'd0; db_en = 8'h01; pad_in = 8'h00;
            db_limit = 8'(l);
            do_reset();
            pad_in = 8'h01;
            for (int k = 1; k <= 4; k++) begin
                step();
                chk($sformatf("lim%0d_gpio%0d", l, k), 32'(GPIO_IN[0]), 32'(k >= 3));
                chk($sformatf("lim%0d_rise%0d", l, k), 32'(rise_pulse[0]), 32'(k == 3));
            end
        end

        // mixed bypass/debounce, then reset mid-count and restart
        db_en = 8'hF0; pad_in = 8'h00; db_limit = 8'd5; presc_div = 16'd0;
        do_reset();
        pad_in = 8'hFF;
        mixed_run();
        pad_in = 8'h00;
        do_reset();
        pad_in = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("mid_gpio", GPIO_IN, (k >= 3) ? 8'h0F : 8'h00);
        end
        do_reset();
        chk("mid_rst_gpio", GPIO_IN, 8'h00);
        chk("mid_rst_rise", rise_pulse, 8'h00);
        chk("mid_rst_tick", 32'(tick), 32'(0));
        mixed_run();

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic [7:0] flip;
            PRESET = ($urandom_range(99) == 0);
            if ($urandom_range(31) == 0) presc_div = 16'($urandom_range(3));
            if ($urandom_range(31) == 0) db_limit = 8'($urandom_range(4));
            if ($urandom_range(63) == 0) db_en = 8'($urandom);
            flip = '0;
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(15) == 0);
            pad_in = pad_in ^ flip;
            step();
            chk("rnd_gpio", GPIO_IN, m_gpio);
            chk("rnd_rise", rise_pulse, m_rise);
            chk("rnd_fall", fall_pulse, m_fall);
            chk("rnd_tick", 32'(tick), 32'(m_tick));
            chk("rnd_excl", rise_pulse & fall_pulse, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
- Input-conditioning stage directly upstream of the APB GPIO block; drives its GPIO_IN bus.
- Per bit: synchronises raw pad inputs into the PCLK domain, then debounces them with a shared sample-tick prescaler and per-bit stability counters.
- Emits single-cycle rise/fall pulses for use as edge-interrupt sources.
- Per-bit bypass allows fast unfiltered inputs.

Parameters:
- IO_NUM, 8, number of input bits.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- PRESC_W, 16, prescaler counter width.
- CNT_W, 8, per-bit debounce counter width.

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  synchronous active-high reset.
- pad_in  input  IO_NUM  raw asynchronous pad inputs.
- db_en  input  IO_NUM  per-bit debounce enable; 0 = bypass.
- presc_div  input  PRESC_W  tick period minus one; 0 = tick every cycle.
- db_limit  input  CNT_W  consecutive mismatching ticks required to accept a change; 0 treated as 1.
- GPIO_IN  output  IO_NUM  conditioned inputs, registered.
- rise_pulse  output  IO_NUM  1-cycle pulse when GPIO_IN[i] goes 0->1.
- fall_pulse  output  IO_NUM  1-cycle pulse when GPIO_IN[i] goes 1->0.
- tick  output  1  prescaler tick, for observation and test.

Behaviour:
- Reset: one clock is synchronous and active-high: PRESET sampled on the PCLK rising edge.
  - PRESET=1 clears all flops on that edge: synchroniser, prescaler, counters, GPIO_IN, rise_pulse, fall_pulse, tick all = 0.
  - Reset dominates every other event, including mid-count.
- Synchroniser: SYNC_STAGES flop chain per bit; sync[i] is the last stage. No logic between stages.
- Prescaler:
  - On each edge: if pcnt >= presc_div then pcnt<=0 and tick<=1; else pcnt<=pcnt+1 and tick<=0.
  - tick is therefore registered and one cycle wide.
  - If presc_div is lowered below pcnt, the next edge wraps pcnt to 0 with a tick; no stall.
- Per-bit debounce, evaluated in priority order:
  1. db_en[i]=0: GPIO_IN[i]<=sync[i] every edge; cnt[i]<=0.
  2. sync[i]==GPIO_IN[i]: cnt[i]<=0 on every edge, regardless of tick. Any glitch restarts the count.
  3. sync[i]!=GPIO_IN[i] and tick=1:
     - if cnt[i]+1 >= max(db_limit,1): GPIO_IN[i]<=sync[i], cnt[i]<=0;
     - else cnt[i]<=cnt[i]+1.
  4. Otherwise hold.
- Counter width: cnt never exceeds db_limit-1, so no wrap. Comparison is done at CNT_W+1 bits.
- If db_limit is changed mid-count to a value <= cnt+1, the change is accepted on the next tick.
- Latency from the first edge that samples a stable new pad level:
  - bypass: GPIO_IN changes on edge SYNC_STAGES+1;
  - debounced with presc_div=0: on edge SYNC_STAGES+db_limit;
  - general case: the db_limit-th tick strictly after edge SYNC_STAGES.
- Pulses:
  - rise_pulse[i]<=~GPIO_IN[i] & next_GPIO_IN[i]; fall_pulse[i] likewise. Both registered, so they are high in the cycle GPIO_IN shows the new value.
  - Never both high on the same bit.
- Toggling db_en[i] from 1 to 0 while a count is in progress: the bit follows sync on the next edge and a pulse is generated if the value changes.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4;
  - default PRESC_W/CNT_W constants;
  - a function max1(x) returning 1 when x==0.
- One natural sub-module, gpio_db_bit: per-bit synchroniser, counter, state and pulse logic. Generated IO_NUM times.
- The top level contains only the prescaler and the generate loop.

Test Plan:
- Reset: hold PRESET=1 for 3 cycles with pad_in=8'hFF -> all outputs 0; release -> with db_en=0, GPIO_IN=8'hFF on edge 3 after release, rise_pulse=8'hFF for exactly 1 cycle.
- Debounce basic: db_en=8'h01, presc_div=0, db_limit=4; pad_in[0] 0->1 held -> GPIO_IN[0]=1 on edge SYNC_STAGES+4 (edge 6); one rise_pulse[0].
- Glitch reject: same config; pad_in[0] high for 3 cycles, low 1 cycle, high again -> no change until 4 consecutive high ticks after the glitch; no pulse during the glitch.
- Prescaler: presc_div=9, db_limit=2 -> tick every 10 cycles; GPIO_IN[0] changes on the 2nd tick after synchronisation, i.e. 11-20 cycles after sync depending on phase. Change presc_div 9->2 while pcnt=7 -> tick on the next edge, then every 3 cycles.
- db_limit=0 and db_limit=1, presc_div=0 -> both change on edge SYNC_STAGES+1, identical to bypass.
- Mixed: db_en=8'hF0; all pads 0->1 simultaneously with presc_div=0, db_limit=5:
  - bits 3:0 change on edge 3, bits 7:4 on edge 7;
  - rise_pulse=8'h0F then 8'hF0 in separate cycles;
  - assert PRESET at edge 5 -> counts cleared, bits 7:4 restart from 0 after release.
